// File: rtl/seg7_scan_ctrl_if.sv
// ----------------------------------------------------------------------------
// seg7_scan_ctrl_if
// Bus bundle between the CPU-side value source and the seven-segment scan
// controller.
//   i_data       32  hex value to show, nibble k -> digit k (digit 0 rightmost)
//   i_dp          8  decimal point per digit, 1 = lit
//   i_we          1  one-cycle strobe capturing i_data/i_dp into pending regs
//   o_seg         8  active-low segments {dp,g,f,e,d,c,b,a}
//   o_sel         8  active-low digit enables, one-hot-low while scanning
//   o_frame_sync  1  one-cycle pulse when pending is committed to the frame
// Modports: master = value source, slave = scan controller.
// ----------------------------------------------------------------------------
interface seg7_scan_ctrl_if;
    logic [31:0] i_data;
    logic [7:0]  i_dp;
    logic        i_we;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;
    logic        o_frame_sync;

    modport master (
        output i_data, i_dp, i_we,
        input  o_seg, o_sel, o_frame_sync
    );

    modport slave (
        input  i_data, i_dp, i_we,
        output o_seg, o_sel, o_frame_sync
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg7_scan_ctrl
// Scan scheduler for an 8-digit multiplexed seven-segment display. Each digit
// is enabled for SCAN_DIV clocks in turn (digit 0 first). Values written via
// i_we land in pending registers and are copied to the displayed frame only at
// the end of digit 7, so a frame never mixes old and new data.
//
// Ports:
//   clk  in  system clock, all logic on posedge
//   rst  in  synchronous reset, active-high
//   bus  seg7_scan_ctrl_if.slave (i_data, i_dp, i_we in; o_seg, o_sel,
//        o_frame_sync out, all outputs registered)
//
// Parameters:
//   SCAN_DIV  clocks per digit, >= 2
//   CNT_W     prescaler width, 2**CNT_W >= SCAN_DIV
//
// Optional feature macro: SEG7_LZB_EN
//   Defined   -> leading-zero blanking: digits above the highest nonzero
//                nibble of the committed frame are dark unless their dp is lit.
//   Undefined -> every digit is always decoded.
// ----------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int SCAN_DIV = 100000,
    parameter int CNT_W    = 17
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_ctrl_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Hex digit to active-high segments, bit order gfedcba.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

`ifdef SEG7_LZB_EN
    // Index of the highest nonzero nibble; 0 when the whole value is zero.
    function automatic logic [2:0] msd_of(input logic [31:0] val);
        logic [2:0] msd;
        msd = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (val[4*i +: 4] != 4'h0) begin
                msd = 3'(i);
            end
        end
        return msd;
    endfunction
`endif

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      pending_q, pending_d;
    logic [7:0]       pending_dp_q, pending_dp_d;
    logic [31:0]      frame_q, frame_d;
    logic [7:0]       frame_dp_q, frame_dp_d;
    logic [7:0]       sel_q, sel_d;
    logic [7:0]       seg_q, seg_d;
    logic             sync_q, sync_d;
`ifdef SEG7_LZB_EN
    logic [2:0]       msd_q, msd_d;
`endif

    logic             tick;
    logic             commit;
    logic [3:0]       nibble;

    always_comb begin
        tick   = (cnt_q == CNT_LAST);
        commit = tick && (idx_q == 3'd7);

        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_q + 3'd1 : idx_q;

        // On a commit edge the frame takes the pre-edge pending value, so a
        // write landing on that same edge only shows up one frame later.
        frame_d    = commit ? pending_q    : frame_q;
        frame_dp_d = commit ? pending_dp_q : frame_dp_q;
        sync_d     = commit;

        pending_d    = bus.i_we ? bus.i_data : pending_q;
        pending_dp_d = bus.i_we ? bus.i_dp   : pending_dp_q;

        nibble = frame_q[{idx_q, 2'b00} +: 4];
        sel_d  = ~(8'b1 << idx_q);
        seg_d  = {~frame_dp_q[idx_q], ~hex7(nibble)};

`ifdef SEG7_LZB_EN
        msd_d = commit ? msd_of(pending_q) : msd_q;
        // msd is never below 0, so digit 0 can never satisfy idx > msd.
        if ((idx_q > msd_q) && !frame_dp_q[idx_q]) begin
            seg_d = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= 3'd0;
            pending_q    <= 32'd0;
            pending_dp_q <= 8'd0;
            frame_q      <= 32'd0;
            frame_dp_q   <= 8'd0;
            sel_q        <= 8'hFF;
            seg_q        <= 8'hFF;
            sync_q       <= 1'b0;
`ifdef SEG7_LZB_EN
            msd_q        <= 3'd0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            pending_dp_q <= pending_dp_d;
            frame_q      <= frame_d;
            frame_dp_q   <= frame_dp_d;
            sel_q        <= sel_d;
            seg_q        <= seg_d;
            sync_q       <= sync_d;
`ifdef SEG7_LZB_EN
            msd_q        <= msd_d;
`endif
        end
    end

    assign bus.o_sel        = sel_q;
    assign bus.o_seg        = seg_q;
    assign bus.o_frame_sync = sync_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed bench for seg7_scan_ctrl with SCAN_DIV=4 (32-clock frames).
// Expected segment codes per written value are hand-computed byte tables
// {digit7..digit0}; the bench tracks which table is pending and which is
// displayed, and checks o_sel/o_seg/o_frame_sync after every edge.
// Honours SEG7_LZB_EN for the expected blanking of leading digits.
// ----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    seg7_scan_ctrl_if bus ();

    seg7_scan_ctrl #(
        .SCAN_DIV (4),
        .CNT_W    (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;
    bit scan_on  = 1'b0;

    // Digit enable pattern for digits 7..0.
    logic [63:0] sel_tab = 64'h7FBF_DFEF_F7FB_FDFE;

    logic [63:0] frame_tab, pend_tab, stage_tab;
    logic [7:0]  frame_dp, pend_dp, stage_dp;
    int          frame_msd, pend_msd, stage_msd;
    bit          staged = 1'b0;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s edge=%0d observed=%h expected=%h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic resetModel();
        frame_tab = {8{8'hC0}};
        pend_tab  = {8{8'hC0}};
        frame_dp  = 8'h00;
        pend_dp   = 8'h00;
        frame_msd = 0;
        pend_msd  = 0;
        staged    = 1'b0;
        edge_n    = 0;
    endtask

    // Advance one clock, then check the registered outputs against the frame
    // that was displayed before this edge, then update the model state.
    task automatic tick();
        int d;
        logic [7:0] exp_seg;
        @(posedge clk);
        #1;
        edge_n++;
        if (scan_on) begin
            d = ((edge_n - 1) / 4) % 8;
            exp_seg = frame_tab[8*d +: 8];
`ifdef SEG7_LZB_EN
            if ((d > frame_msd) && !frame_dp[d]) exp_seg = 8'hFF;
`endif
            checkOutput("o_sel", bus.o_sel, sel_tab[8*d +: 8]);
            checkOutput("o_seg", bus.o_seg, exp_seg);
            checkOutput("sel_onehot", 8'($countones(~bus.o_sel)), 8'd1);
            checkOutput("frame_sync", {7'd0, bus.o_frame_sync}, (edge_n % 32 == 0) ? 8'd1 : 8'd0);
            if (edge_n % 32 == 0) begin
                frame_tab = pend_tab;
                frame_dp  = pend_dp;
                frame_msd = pend_msd;
            end
        end
        if (staged) begin
            pend_tab = stage_tab;
            pend_dp  = stage_dp;
            pend_msd = stage_msd;
            staged   = 1'b0;
        end
    endtask

    // Pulse i_we for one clock; segs is the expected o_seg per digit, msd the
    // highest nonzero nibble of data.
    task automatic applyStimulus(input logic [31:0] data, input logic [7:0] dp,
                                 input logic [63:0] segs, input int msd);
        bus.i_data = data;
        bus.i_dp   = dp;
        bus.i_we   = 1'b1;
        stage_tab  = segs;
        stage_dp   = dp;
        stage_msd  = msd;
        staged     = 1'b1;
        tick();
        bus.i_we   = 1'b0;
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_o_sel", bus.o_sel, 8'hFF);
        checkOutput("rst_o_seg", bus.o_seg, 8'hFF);
        checkOutput("rst_frame_sync", {7'd0, bus.o_frame_sync}, 8'd0);
    endtask

    initial begin
        $display("[TB] seg7_scan_ctrl directed test, SCAN_DIV=4");
        resetModel();
        bus.i_data = 32'd0;
        bus.i_dp   = 8'd0;
        bus.i_we   = 1'b0;
        rst        = 1'b1;

        // Reset held three cycles.
        repeat (3) begin
            tick();
            checkResetOutputs();
        end
        rst = 1'b0;
        resetModel();
        scan_on = 1'b1;

        // Full frame of zeros plus wrap to digit 0.
        repeat (39) tick();

        // 1234ABCD written mid-frame, committed at edge 64.
        applyStimulus(32'h1234_ABCD, 8'h00, 64'hF9A4_B099_8883_C6A1, 7);
        repeat (29) tick();

        // Zero with digit-0 dp, committed at edge 96.
        applyStimulus(32'h0000_0000, 8'h01, 64'hC0C0_C0C0_C0C0_C040, 0);
        repeat (25) tick();

        // Write landing exactly on the commit edge 96.
        applyStimulus(32'hFFFF_FFFF, 8'h00, {8{8'h8E}}, 7);
        repeat (3) tick();

        // Two writes in one frame: the later one must be committed at 128.
        applyStimulus(32'h8765_4321, 8'h00, 64'h80F8_8292_99B0_A4F9, 7);
        repeat (9) tick();
        applyStimulus(32'hFFFF_FFFF, 8'h00, {8{8'h8E}}, 7);
        repeat (39) tick();

        // Reset while digit 5 is scanning, with a write attempted at the same time.
        scan_on    = 1'b0;
        rst        = 1'b1;
        bus.i_we   = 1'b1;
        bus.i_data = 32'h5555_5555;
        bus.i_dp   = 8'hFF;
        repeat (2) begin
            tick();
            checkResetOutputs();
        end
        rst        = 1'b0;
        bus.i_we   = 1'b0;
        bus.i_data = 32'd0;
        bus.i_dp   = 8'd0;
        resetModel();
        scan_on = 1'b1;

        // Restart at digit 0 with full dwell; next committed frame is all zero.
        repeat (66) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
